// File: rtl/mole_led_driver_pkg.sv
// Shared constants and key-code helpers for the mole LED driver and keypad scanner.
// Key codes are {column[1:0], row[1:0]}; LED bit index is col*3 + row.
package mole_led_driver_pkg;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } cmd_op_t;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 3;
    localparam int KEY_W    = 4;
    localparam int LED_W    = NUM_COLS * NUM_ROWS;

    typedef struct packed {
        logic       valid;
        logic [3:0] index;
    } key_index_t;

    // A key is valid only when both fields fall inside the 3x3 matrix.
    function automatic key_index_t key_to_index(input logic [KEY_W-1:0] key);
        key_index_t r;
        r.valid = (key[3:2] < 2'(NUM_COLS)) && (key[1:0] < 2'(NUM_ROWS));
        r.index = {2'b00, key[3:2]} * 4'(NUM_ROWS) + {2'b00, key[1:0]};
        return r;
    endfunction

endpackage

// File: rtl/mole_led_driver_if.sv
// Valid/ready command port used by game logic to update the LED pattern.
interface mole_led_driver_if;
    import mole_led_driver_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    cmd_op_t               cmd_op;
    logic [KEY_W-1:0]      cmd_key;
    logic [LED_W-1:0]      cmd_data;
    logic                  cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_data,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_data,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/mole_led_driver_led_scan_timer.sv
// Column scan timing: prescaler, slot phase and column index, plus the
// frame-boundary and blanking strobes derived from them.
module led_scan_timer #(
    parameter int SCAN_DIV    = 50,
    parameter int SLOT_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       frame_boundary,
    output logic       blank,
    output logic [1:0] col
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(SLOT_TICKS);

    logic [PW-1:0] presc;
    logic [SW-1:0] p;
    logic          tick;

    assign tick           = (presc == PW'(SCAN_DIV - 1));
    assign frame_boundary = tick && (col == 2'd2) && (p == SW'(SLOT_TICKS - 1));
    assign blank          = (p < SW'(BLANK_TICKS));

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            p     <= '0;
            col   <= 2'd0;
        end else if (tick) begin
            presc <= '0;
            if (p == SW'(SLOT_TICKS - 1)) begin
                p   <= '0;
                col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
            end else begin
                p <= p + SW'(1);
            end
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/mole_led_driver.sv
// Scanned 3x3 LED matrix driver with a double-buffered pattern that is
// committed only at frame boundaries.
module mole_led_driver
    import mole_led_driver_pkg::*;
#(
    parameter int SCAN_DIV    = 50,
    parameter int SLOT_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic                clk,
    input  logic                reset,
    mole_led_driver_if.slave    cmd,
    output logic                frame_done,
    output logic [2:0]          column,
    output logic [2:0]          row
);

    logic             frame_boundary;
    logic             blank;
    logic [1:0]       col;
    logic [LED_W-1:0] shadow;
    logic [LED_W-1:0] active;
    logic [LED_W-1:0] shadow_next;
    logic [LED_W-1:0] bit_mask;
    logic             dirty;
    logic             dirty_set;
    logic             ready_q;
    logic             accept;
    logic [2:0]       col_rows;
    key_index_t       kidx;

    led_scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .SLOT_TICKS  (SLOT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .frame_boundary (frame_boundary),
        .blank          (blank),
        .col            (col)
    );

    // The commit cycle refuses commands so shadow is stable while it is copied.
    assign cmd.cmd_ready = ready_q & ~frame_boundary;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign kidx          = key_to_index(cmd.cmd_key);
    assign bit_mask      = LED_W'(1) << kidx.index;

    always_comb begin
        shadow_next = shadow;
        dirty_set   = 1'b0;
        if (accept) begin
            case (cmd.cmd_op)
                OP_LOAD: begin
                    shadow_next = cmd.cmd_data;
                    dirty_set   = 1'b1;
                end
                OP_SET: begin
                    shadow_next = shadow | bit_mask;
                    dirty_set   = kidx.valid;
                end
                OP_CLEAR: begin
                    shadow_next = shadow & ~bit_mask;
                    dirty_set   = kidx.valid;
                end
                default: begin
                    shadow_next = shadow ^ bit_mask;
                    dirty_set   = kidx.valid;
                end
            endcase
            if (!dirty_set) begin
                shadow_next = shadow;
            end
        end
    end

    always_comb begin
        case (col)
            2'd0:    col_rows = active[2:0];
            2'd1:    col_rows = active[5:3];
            default: col_rows = active[8:6];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow     <= '0;
            active     <= '0;
            dirty      <= 1'b0;
            ready_q    <= 1'b0;
            cmd.cmd_err <= 1'b0;
            frame_done <= 1'b0;
            column     <= 3'b111;
            row        <= 3'b000;
        end else begin
            ready_q     <= 1'b1;
            frame_done  <= frame_boundary;
            cmd.cmd_err <= accept && (cmd.cmd_op != OP_LOAD) && !kidx.valid;
            column      <= blank ? 3'b111 : ~(3'b001 << col);
            row         <= blank ? 3'b000 : col_rows;
            shadow      <= shadow_next;
            // Accepts and commits never share a cycle, so dirty has one writer per edge.
            if (frame_boundary && dirty) begin
                active <= shadow;
                dirty  <= 1'b0;
            end else if (dirty_set) begin
                dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mole_led_driver.sv
// Randomized and directed bench for mole_led_driver against a cycle-count based model.
module tb_mole_led_driver;
    import mole_led_driver_pkg::*;

    localparam int SCAN_DIV    = 3;
    localparam int SLOT_TICKS  = 4;
    localparam int BLANK_TICKS = 1;
    localparam int FRAME       = 3 * SLOT_TICKS * SCAN_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_done;
    logic [2:0] column;
    logic [2:0] row;

    mole_led_driver_if cmd_bus ();

    mole_led_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .SLOT_TICKS  (SLOT_TICKS),
        .BLANK_TICKS (BLANK_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cmd_bus.slave),
        .frame_done (frame_done),
        .column     (column),
        .row        (row)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;

    // Model state: time is just the number of non-reset edges since reset.
    int         m_cyc = 0;
    logic [8:0] m_shadow = '0;
    logic [8:0] m_active = '0;
    bit         m_dirty = 0;
    bit         m_ready_reg = 0;
    bit         last_accept = 0;
    logic [2:0] e_column = 3'b111;
    logic [2:0] e_row = 3'b000;
    bit         e_err = 0;
    bit         e_done = 0;
    int         mp, mc, mbit;
    bit         mbnd, macc, mkey_ok;

    function automatic bit boundary_at(int cyc);
        int t = cyc / SCAN_DIV;
        return (cyc % SCAN_DIV == SCAN_DIV - 1) && (t % (3 * SLOT_TICKS) == 3 * SLOT_TICKS - 1);
    endfunction

    function automatic int phase_at(int cyc);
        return (cyc / SCAN_DIV) % SLOT_TICKS;
    endfunction

    function automatic int col_at(int cyc);
        return (cyc / (SCAN_DIV * SLOT_TICKS)) % 3;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc = 0; m_shadow = '0; m_active = '0; m_dirty = 0; m_ready_reg = 0;
            last_accept = 0; e_column = 3'b111; e_row = 3'b000; e_err = 0; e_done = 0;
        end else begin
            mp   = phase_at(m_cyc);
            mc   = col_at(m_cyc);
            mbnd = boundary_at(m_cyc);
            macc = cmd_bus.cmd_valid && m_ready_reg && !mbnd;
            e_column = (mp < BLANK_TICKS) ? 3'b111 : 3'(~(1 << mc));
            e_row    = (mp < BLANK_TICKS) ? 3'b000 : 3'((m_active >> (mc * 3)) & 9'h7);
            e_done   = mbnd;
            mkey_ok  = (cmd_bus.cmd_key[3:2] != 2'd3) && (cmd_bus.cmd_key[1:0] != 2'd3);
            mbit     = int'(cmd_bus.cmd_key[3:2]) * 3 + int'(cmd_bus.cmd_key[1:0]);
            e_err    = macc && (cmd_bus.cmd_op != OP_LOAD) && !mkey_ok;
            if (mbnd && m_dirty) begin
                m_active = m_shadow;
                m_dirty  = 0;
            end
            if (macc) begin
                if (cmd_bus.cmd_op == OP_LOAD) begin
                    m_shadow = cmd_bus.cmd_data;
                    m_dirty  = 1;
                end else if (mkey_ok) begin
                    case (cmd_bus.cmd_op)
                        OP_SET:   m_shadow[mbit] = 1'b1;
                        OP_CLEAR: m_shadow[mbit] = 1'b0;
                        default:  m_shadow[mbit] = ~m_shadow[mbit];
                    endcase
                    m_dirty = 1;
                end
            end
            last_accept = macc;
            m_ready_reg = 1;
            m_cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("column", 9'(column), 9'(e_column));
            checkOutput("row", 9'(row), 9'(e_row));
            checkOutput("frame_done", 9'(frame_done), 9'(e_done));
            checkOutput("cmd_err", 9'(cmd_bus.cmd_err), 9'(e_err));
            checkOutput("cmd_ready", 9'(cmd_bus.cmd_ready), 9'(m_ready_reg && !boundary_at(m_cyc)));
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] key, input logic [8:0] data);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = cmd_op_t'(op);
        cmd_bus.cmd_key   = key;
        cmd_bus.cmd_data  = data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (last_accept) begin
                cmd_bus.cmd_valid = 1'b0;
                return;
            end
        end
        cmd_bus.cmd_valid = 1'b0;
        checks++; errors++;
        $display("[TB] FAIL accept_timeout actual=0 required=1 at %0t", $time);
    endtask

    task automatic waitFrameDone();
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge clk);
            if (frame_done) return;
        end
        checks++; errors++;
        $display("[TB] FAIL frame_done_timeout actual=0 required=1 at %0t", $time);
    endtask

    // Watches one full frame and counts slots that disagree with a literal pattern.
    task automatic observeFrame(input logic [8:0] pat, output int bad, output int dones, output logic [2:0] seen);
        logic [2:0] want;
        bad = 0; dones = 0; seen = 3'b000;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (frame_done) dones++;
            case (column)
                3'b111:  want = 3'b000;
                3'b110:  begin want = pat[2:0]; seen[0] = 1'b1; end
                3'b101:  begin want = pat[5:3]; seen[1] = 1'b1; end
                3'b011:  begin want = pat[8:6]; seen[2] = 1'b1; end
                default: begin want = 3'bxxx; bad++; end
            endcase
            if (row !== want) bad++;
        end
    endtask

    int         bad, dones, cnt;
    logic [2:0] seen;

    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = OP_LOAD;
        cmd_bus.cmd_key   = 4'h0;
        cmd_bus.cmd_data  = 9'h0;
        reset = 1'b1;
        @(posedge clk);
        check_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("lit_reset_column", 9'(column), 9'h7);
        checkOutput("lit_reset_row", 9'(row), 9'h0);
        checkOutput("lit_reset_ready", 9'(cmd_bus.cmd_ready), 9'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("lit_ready_after_reset", 9'(cmd_bus.cmd_ready), 9'h1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) cnt++;
        end
        checkOutput("lit_no_early_frame_done", 9'(cnt), 9'h0);

        applyStimulus(2'b00, 4'h0, 9'h1FF);
        cnt = 0;
        for (int i = 0; i < FRAME + 10 && !frame_done; i++) begin
            if (row !== 3'b000) cnt++;
            @(negedge clk);
        end
        checkOutput("lit_load_held_until_boundary", 9'(cnt), 9'h0);
        checkOutput("lit_load_boundary_seen", 9'(frame_done), 9'h1);
        observeFrame(9'h1FF, bad, dones, seen);
        checkOutput("lit_load_all_lit", 9'(bad), 9'h0);
        checkOutput("lit_load_slots_seen", 9'(seen), 9'h7);
        checkOutput("lit_load_one_frame_done", 9'(dones), 9'h1);

        waitFrameDone();
        applyStimulus(2'b00, 4'h0, 9'h000);
        applyStimulus(2'b01, 4'b0101, 9'h000);
        waitFrameDone();
        observeFrame(9'h010, bad, dones, seen);
        checkOutput("lit_set_only_bit4", 9'(bad), 9'h0);
        checkOutput("lit_set_col1_seen", 9'(seen[1]), 9'h1);

        applyStimulus(2'b11, 4'b1100, 9'h000);
        checkOutput("lit_toggle_err_pulse", 9'(cmd_bus.cmd_err), 9'h1);
        @(negedge clk);
        checkOutput("lit_toggle_err_one_cycle", 9'(cmd_bus.cmd_err), 9'h0);
        waitFrameDone();
        observeFrame(9'h010, bad, dones, seen);
        checkOutput("lit_toggle_pattern_kept", 9'(bad), 9'h0);

        for (int i = 0; i < FRAME + 5 && !boundary_at(m_cyc); i++) @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = OP_LOAD;
        cmd_bus.cmd_data  = 9'h0AA;
        checkOutput("lit_hold_ready_low", 9'(cmd_bus.cmd_ready), 9'h0);
        @(negedge clk);
        checkOutput("lit_hold_ready_back", 9'(cmd_bus.cmd_ready), 9'h1);
        @(negedge clk);
        checkOutput("lit_hold_accepted", 9'(last_accept), 9'h1);
        cmd_bus.cmd_valid = 1'b0;
        waitFrameDone();
        observeFrame(9'h0AA, bad, dones, seen);
        checkOutput("lit_hold_displayed", 9'(bad), 9'h0);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!(cmd_bus.cmd_valid && !last_accept)) begin
                cmd_bus.cmd_valid = ($urandom_range(0, 3) == 0);
                cmd_bus.cmd_op    = cmd_op_t'($urandom_range(0, 3));
                cmd_bus.cmd_key   = 4'($urandom_range(0, 15));
                cmd_bus.cmd_data  = 9'($urandom_range(0, 511));
            end
        end
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;

        waitFrameDone();
        applyStimulus(2'b00, 4'h0, 9'h155);
        for (int i = 0; i < FRAME && !(col_at(m_cyc) == 1 && phase_at(m_cyc) == 2); i++) @(negedge clk);
        checkOutput("lit_midreset_pending", 9'(m_dirty), 9'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("lit_midreset_column", 9'(column), 9'h7);
        checkOutput("lit_midreset_row", 9'(row), 9'h0);
        checkOutput("lit_midreset_ready", 9'(cmd_bus.cmd_ready), 9'h0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            if (row !== 3'b000) cnt++;
        end
        checkOutput("lit_midreset_never_shown", 9'(cnt), 9'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
